fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch initiator for the pipelined core. It drives word-aligned addresses to the instruction memory port and collects the returned instruction words in a small FIFO. It presents them in program order, each tagged with its PC, to the decode stage through a valid/ready handshake. Branch/jump redirects flush all buffered and in-flight instructions and restart fetch at the new PC.

## Interface

Parameters:
- ADDRESS_WIDTH, 32: PC / memory address width
- DATA_WIDTH, 32: instruction width
- RESET_PC, 32'h0000_0000: first fetch address after reset
- FIFO_DEPTH, 4: instruction buffer entries; also the maximum in-flight plus buffered count (power of 2, ≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  request valid
- imem_addr  out  ADDRESS_WIDTH  request address, bits [1:0] always 0
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response valid; one per accepted request, in order
- imem_rdata  in  DATA_WIDTH  response instruction
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  ADDRESS_WIDTH  new PC; bits [1:0] ignored, treated as 0
- instr_valid  out  1  FIFO head valid
- instr  out  DATA_WIDTH  FIFO head instruction, 0 when empty
- instr_pc  out  ADDRESS_WIDTH  FIFO head PC, 0 when empty
- instr_ready  in  1  decode consumes head when instr_valid is high

## Operation

- State: pc (next fetch address), resp_pc (PC of next kept response), outstanding (accepted and not yet responded), drop_cnt (responses to discard), FIFO of {pc, instr}.
- Counter widths: outstanding and drop_cnt are $clog2(FIFO_DEPTH+1) bits.
- Request: imem_req = !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH); imem_addr = pc.
- Accept: imem_req && imem_ready. On accept, pc <= pc + 4, wrapping modulo 2^ADDRESS_WIDTH, and outstanding increments.
- Response: every imem_rvalid decrements outstanding.
  - If drop_cnt > 0: discard the response and decrement drop_cnt.
  - Otherwise: push {resp_pc, imem_rdata} and set resp_pc <= resp_pc + 4.
- The credit rule guarantees a push never meets a full FIFO. imem_rvalid with outstanding == 0 is a protocol error; ignore it.
- Pop: instr_valid && instr_ready.
- Redirect, which has priority over everything else:
  - pc <= redirect_pc & ~3 and resp_pc <= redirect_pc & ~3.
  - FIFO is cleared; a simultaneous pop or push is discarded.
  - drop_cnt <= outstanding − (imem_rvalid ? 1 : 0).
  - outstanding is updated normally; no request is issued in the redirect cycle.
- Back-to-back redirects: the last one wins. drop_cnt is recomputed from the current outstanding each time and is never accumulated.

## Timing

- Reset values:
  - imem_req 0 while rst is high; imem_addr = RESET_PC.
  - instr_valid 0; instr 0; instr_pc 0.
  - pc = resp_pc = RESET_PC; outstanding = drop_cnt = 0.
- The first cycle after rst deasserts has imem_req = 1 and imem_addr = RESET_PC.
- A response is accepted at edge N and appears on instr_valid/instr after edge N+1. The FIFO output is registered state; there is no bypass.
- Memory response latency is ≥1 cycle after acceptance. With FIFO_DEPTH=4 and a 1-cycle memory, fetch sustains 1 instr/cycle while decode is always ready.
- Decode stall (instr_ready=0): the FIFO fills, the credit limit drops imem_req, and nothing is lost. Fetch resumes the cycle after a pop frees a credit.
- Redirect at edge N: instr_valid = 0 after N. A request to redirect_pc is issued in cycle N+1 if credits allow.
- The memory must be reset by the same rst. After reset, no responses for pre-reset requests may arrive.

## Structure

- Shared package fetch_pkg holds:
  - the RESET_PC default;
  - the instruction word size constant (4);
  - the NOP encoding 32'h0000_0013 for downstream bubble insertion.
- Sub-module fetch_fifo: synchronous FIFO of width ADDRESS_WIDTH+DATA_WIDTH and depth FIFO_DEPTH, with ports push, pop, clear, count, and head.
- fetch_unit contains pc, resp_pc, the counters, and the request/credit logic.

## Test plan

- Reset release, 1-cycle memory, instr_ready=1 → addresses 0x0, 0x4, 0x8… issued on consecutive cycles; instr_pc 0x0, 0x4… with matching rdata, one per cycle from cycle 3.
- imem_ready=0 for 3 cycles → imem_addr held at 0x0; no duplicate or skipped PC afterward.
- instr_ready=0 indefinitely → exactly 4 instructions buffered, imem_req drops, outstanding=0; releasing ready drains 0x0–0xC, then fetch resumes at 0x10.
- 3-cycle latency memory with 3 requests in flight, redirect_pc=0x103 → the 3 responses are dropped; the next delivered instr_pc is 0x100, then 0x104.
- Redirect in the same cycle as imem_rvalid and a pop → the response and the popped head are discarded; drop_cnt = outstanding − 1; the next delivered PC is the redirect target.
- rst asserted mid-stream with a full FIFO → all outputs are at reset values immediately (asynchronously); after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch front end.
// Holds the default reset PC, the instruction word size and the bubble encoding.
package fetch_pkg;

   localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
   localparam int unsigned INSTR_BYTES    = 4;
   localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

   // What happens to a memory response arriving this cycle.
   typedef enum logic [1:0] {
      RSP_IDLE,
      RSP_PUSH,
      RSP_DROP
   } rspAction_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer holding {pc, instr} pairs in program order.
// Clear empties it in one cycle and overrides any push or pop in that cycle.
module fetch_fifo #(
   parameter int WIDTH       = 64,
   parameter int DEPTH       = 4,
   parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   clear,
   input  logic [WIDTH-1:0]       push_data,
   output logic [COUNT_WIDTH-1:0] count,
   output logic [WIDTH-1:0]       head
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0]       r_mem [DEPTH];
   logic [PW-1:0]          r_rdPtr;
   logic [PW-1:0]          r_wrPtr;
   logic [COUNT_WIDTH-1:0] r_count;
   logic                   w_push;
   logic                   w_pop;

   assign w_pop  = pop && (r_count != '0) && !clear;
   assign w_push = push && ((r_count != COUNT_WIDTH'(DEPTH)) || w_pop) && !clear;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else if (clear) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
         if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
         r_count <= r_count + COUNT_WIDTH'(w_push) - COUNT_WIDTH'(w_pop);
      end
   end

   // Storage needs no reset; the count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wrPtr] <= push_data;
   end

   assign count = r_count;
   assign head  = r_mem[r_rdPtr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch initiator: issues word-aligned requests under a credit limit,
// buffers in-order responses tagged with their PC, and flushes on redirect.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                       ADDRESS_WIDTH = 32,
   parameter int                       DATA_WIDTH    = 32,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(FETCH_RESET_PC),
   parameter int                       FIFO_DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     imem_req,
   output logic [ADDRESS_WIDTH-1:0] imem_addr,
   input  logic                     imem_ready,
   input  logic                     imem_rvalid,
   input  logic [DATA_WIDTH-1:0]    imem_rdata,
   input  logic                     redirect_valid,
   input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
   output logic                     instr_valid,
   output logic [DATA_WIDTH-1:0]    instr,
   output logic [ADDRESS_WIDTH-1:0] instr_pc,
   input  logic                     instr_ready
);

   localparam int                       CW          = $clog2(FIFO_DEPTH + 1);
   localparam logic [ADDRESS_WIDTH-1:0] STEP        = ADDRESS_WIDTH'(INSTR_BYTES);
   localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK  = ~ADDRESS_WIDTH'(3);
   localparam logic [ADDRESS_WIDTH-1:0] RESET_ALIGN = RESET_PC & ALIGN_MASK;
   localparam logic [CW:0]              DEPTH_LIMIT = (CW + 1)'(FIFO_DEPTH);

   logic [ADDRESS_WIDTH-1:0]            r_pc;
   logic [ADDRESS_WIDTH-1:0]            r_respPc;
   logic [CW-1:0]                       r_outstanding;
   logic [CW-1:0]                       r_dropCnt;
   logic [CW-1:0]                       w_fifoCount;
   logic [CW:0]                         w_inUse;
   logic [ADDRESS_WIDTH-1:0]            w_redirPc;
   logic [ADDRESS_WIDTH+DATA_WIDTH-1:0] w_head;
   logic                                w_accept;
   logic                                w_rspValid;
   logic                                w_push;
   logic                                w_pop;
   logic                                w_instrValid;
   rspAction_e                          w_rspAction;

   assign w_redirPc = redirect_pc & ALIGN_MASK;
   assign w_inUse   = {1'b0, r_outstanding} + {1'b0, w_fifoCount};
   assign imem_req  = !rst && !redirect_valid && (w_inUse < DEPTH_LIMIT);
   assign imem_addr = r_pc;
   assign w_accept  = imem_req && imem_ready;

   // A response with nothing outstanding is a protocol error and is ignored.
   always_comb begin
      w_rspAction = RSP_IDLE;
      if (imem_rvalid && (r_outstanding != '0)) begin
         w_rspAction = (r_dropCnt != '0) ? RSP_DROP : RSP_PUSH;
      end
   end

   assign w_rspValid   = (w_rspAction != RSP_IDLE);
   assign w_push       = (w_rspAction == RSP_PUSH) && !redirect_valid;
   assign w_instrValid = (w_fifoCount != '0);
   assign w_pop        = w_instrValid && instr_ready && !redirect_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc     <= RESET_ALIGN;
         r_respPc <= RESET_ALIGN;
      end else if (redirect_valid) begin
         r_pc     <= w_redirPc;
         r_respPc <= w_redirPc;
      end else begin
         if (w_accept) r_pc     <= r_pc + STEP;
         if (w_push)   r_respPc <= r_respPc + STEP;
      end
   end

   // Every request still in flight at a redirect belongs to the old stream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_outstanding <= '0;
         r_dropCnt     <= '0;
      end else begin
         r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rspValid);
         if (redirect_valid) begin
            r_dropCnt <= r_outstanding - CW'(w_rspValid);
         end else if (w_rspAction == RSP_DROP) begin
            r_dropCnt <= r_dropCnt - CW'(1);
         end
      end
   end

   fetch_fifo #(
      .WIDTH       (ADDRESS_WIDTH + DATA_WIDTH),
      .DEPTH       (FIFO_DEPTH),
      .COUNT_WIDTH (CW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push),
      .pop       (w_pop),
      .clear     (redirect_valid),
      .push_data ({r_respPc, imem_rdata}),
      .count     (w_fifoCount),
      .head      (w_head)
   );

   assign instr_valid = w_instrValid;
   assign instr       = w_instrValid ? w_head[DATA_WIDTH-1:0] : '0;
   assign instr_pc    = w_instrValid ? w_head[ADDRESS_WIDTH+DATA_WIDTH-1:DATA_WIDTH] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural memory plus an epoch-tagged
// model of the delivered instruction stream, driven by directed and random phases.
module tb_fetch_unit;

   localparam int          DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b0;

   typedef struct {
      logic [31:0] addr;
      int          due;
      int          epoch;
   } memReq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } instr_t;

   memReq_t     memQ[$];
   instr_t      expQ[$];
   logic [31:0] modelPc;
   int          epoch;
   int          cycle;
   int          lat;
   int          testsRun;
   int          testsFailed;

   fetch_unit #(
      .ADDRESS_WIDTH (32),
      .DATA_WIDTH    (32),
      .RESET_PC      (RST_PC),
      .FIFO_DEPTH    (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memData(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed %h, expected %h (cycle %0d)", tag, observed, expected, cycle);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, then advance the model.
   task automatic applyStimulus(input logic ir, input logic mr, input logic redir,
                                input logic [31:0] rpc, input logic respOk);
      memReq_t r;
      logic    rsp;
      logic    expReq;
      logic    expValid;
      rsp = respOk && (memQ.size() > 0) && (memQ[0].due <= cycle);
      instr_ready    = ir;
      imem_ready     = mr;
      redirect_valid = redir;
      redirect_pc    = rpc;
      imem_rvalid    = rsp;
      imem_rdata     = rsp ? memData(memQ[0].addr) : 32'hDEAD_BEEF;
      @(negedge clk);
      expReq   = !redir && ((memQ.size() + expQ.size()) < DEPTH);
      expValid = (expQ.size() > 0);
      checkOutput("imem_req", 32'(imem_req), 32'(expReq));
      checkOutput("imem_addr", imem_addr, modelPc);
      checkOutput("instr_valid", 32'(instr_valid), 32'(expValid));
      checkOutput("instr_pc", instr_pc, expValid ? expQ[0].pc : 32'h0);
      checkOutput("instr", instr, expValid ? expQ[0].data : 32'h0);
      r = '{32'h0, 0, -1};
      if (rsp) r = memQ.pop_front();
      if (redir) begin
         expQ.delete();
         epoch++;
         modelPc = rpc & ~32'h3;
      end else begin
         if (expValid && ir) void'(expQ.pop_front());
         if (rsp && (r.epoch == epoch)) expQ.push_back('{r.addr, memData(r.addr)});
         if (expReq && mr) begin
            memQ.push_back('{modelPc, cycle + lat, epoch});
            modelPc = modelPc + 32'h4;
         end
      end
      @(posedge clk);
      #1;
      cycle++;
   endtask

   // Asserts reset mid-cycle, checks the asynchronous output values, then releases it.
   task automatic resetDut();
      rst = 1'b1;
      #1;
      checkOutput("rst_imem_req", 32'(imem_req), 32'h0);
      checkOutput("rst_imem_addr", imem_addr, RST_PC);
      checkOutput("rst_instr_valid", 32'(instr_valid), 32'h0);
      checkOutput("rst_instr", instr, 32'h0);
      checkOutput("rst_instr_pc", instr_pc, 32'h0);
      memQ.delete();
      expQ.delete();
      epoch++;
      modelPc        = RST_PC;
      imem_rvalid    = 1'b0;
      redirect_valid = 1'b0;
      @(posedge clk);
      #1;
      cycle++;
      rst = 1'b0;
   endtask

   initial begin
      int  waited;
      logic seen;
      testsRun    = 0;
      testsFailed = 0;
      cycle       = 0;
      epoch       = 0;
      lat         = 1;
      modelPc     = RST_PC;
      repeat (2) @(posedge clk);
      #1;
      resetDut();

      // Streaming with a single-cycle memory and an always-ready decoder.
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

      // Memory stalls for three cycles right after reset.
      resetDut();
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

      // Decode stalls: the buffer fills to capacity and requests stop.
      resetDut();
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      checkOutput("stall_req", 32'(imem_req), 32'h0);
      checkOutput("stall_head_pc", instr_pc, 32'h0);
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

      // Three-cycle memory with requests in flight, then a redirect to an unaligned target.
      lat = 3;
      resetDut();
      waited = 0;
      while (memQ.size() < 3 && waited < 10) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
         waited++;
      end
      checkOutput("inflight_before_redirect", 32'(memQ.size()), 32'd3);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0103, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (instr_valid) begin
            seen = 1'b1;
            checkOutput("redirect_first_pc", instr_pc, 32'h0000_0100);
         end else begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
         end
      end
      if (!seen) checkOutput("redirect_delivery_timeout", 32'h0, 32'h1);
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

      // Redirect coinciding with a returning response and a pop of the head.
      lat = 1;
      resetDut();
      waited = 0;
      while (!(memQ.size() > 0 && memQ[0].due <= cycle && expQ.size() > 0) && waited < 10) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
         waited++;
      end
      checkOutput("collision_setup", 32'(waited < 10), 32'h1);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b1);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

      // Random traffic, including back-to-back redirects and variable latency.
      for (int blk = 0; blk < 4; blk++) begin
         lat = int'($urandom_range(1, 3));
         resetDut();
         for (int i = 0; i < 100; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 15) == 0), $urandom, 1'($urandom_range(0, 3) != 0));
         end
      end

      // Reset while the buffer is full, then restart from the reset PC.
      lat = 1;
      resetDut();
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      checkOutput("full_before_reset", 32'(instr_valid), 32'h1);
      resetDut();
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
